ctrl_spi_bank: RTL
==================

CTRL_SPI_BANK -- requirements
Module: ctrl_spi_bank

Interface
REQ-001 SHALL provide parameter BANK_BITS, default 2, meaning width of the high-RAM bank register (1..6).
REQ-002 SHALL provide parameter NSS, default 2, meaning number of active-low slave selects (1..6); BANK_BITS+NSS SHALL be <= 8 (elaboration error otherwise).
REQ-003 SHALL provide parameter DIV, default 1, meaning SCK half-period in CLK cycles (1..255).
REQ-004 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-005 nRST  in  1  asynchronous, active-low reset.
REQ-006 GA  in  16  Gigatron address bus.
REQ-007 nGOE  in  1  Gigatron output enable, active low.
REQ-008 nGWE  in  1  Gigatron write enable, active low.
REQ-009 MISO  in  1  SPI serial input.
REQ-010 SCK  out  1  SPI clock.
REQ-011 MOSI  out  1  SPI serial output.
REQ-012 nSS  out  NSS  slave selects, active low.
REQ-013 BANK  out  BANK_BITS  current RAM bank.
REQ-014 nZPBANK  out  1  zero-page bank swap disable, active low enables swap.
REQ-015 RXDATA  out  8  last received SPI byte.
REQ-016 BUSY  out  1  transfer in progress.
REQ-017 OVR  out  1  sticky: ctrl rejected while BUSY.

Function
REQ-018 Ctrl condition SHALL be !nGOE && !nGWE && GA[3:2]!=2'b00, sampled registered on CLK; only the first cycle of each assertion (rising edge of sampled condition) SHALL act.
REQ-019 Config ctrl (GA[1]=0): BANK<=GA[8 +: BANK_BITS]; nZPBANK<=GA[5]; nSS<=GA[8+BANK_BITS +: NSS]; CPOL<=GA[4]; GA[0]=1 SHALL clear OVR.
REQ-020 Config ctrl while BUSY: BANK and nZPBANK SHALL update; nSS and CPOL SHALL NOT change; OVR SHALL set (unless same ctrl clears it, clear wins).
REQ-021 Transfer ctrl (GA[1]=1) while idle: TX byte = GA[15:8]; BUSY SHALL rise the cycle after the acting edge.
REQ-022 Transfer ctrl while BUSY SHALL be ignored and SHALL set OVR.
REQ-023 FSM states IDLE, LEAD, TRAIL; IDLE->LEAD on accepted transfer; LEAD->TRAIL after DIV cycles; TRAIL->LEAD after DIV cycles if bits remain, else TRAIL->IDLE.
REQ-024 On entry to LEAD, MOSI SHALL present current TX MSB; SCK SHALL equal CPOL in LEAD and !CPOL in TRAIL (mode 0/2 timing: sample on LEAD->TRAIL edge).
REQ-025 MISO SHALL be sampled on the LEAD->TRAIL transition into shift register LSB; TX SHALL shift left on TRAIL->LEAD.
REQ-026 Transfer SHALL take exactly 16*DIV CLK cycles with BUSY=1; 3-bit bit counter SHALL wrap 7->0 marking completion.
REQ-027 RXDATA SHALL update in the same cycle BUSY falls; RXDATA stable otherwise.
REQ-028 In IDLE, SCK=CPOL and MOSI SHALL hold last driven bit.
REQ-029 DIV counter SHALL be width 8 and reload on each phase change; no off-by-one across DIV=1.

Reset
REQ-030 On nRST=0, asynchronously: state IDLE, BUSY=0, OVR=0, BANK=0, nZPBANK=1, nSS=all 1, CPOL=0, SCK=0, MOSI=0, RXDATA=8'h00, shift/counters 0.
REQ-031 Reset asserted mid-transfer SHALL abort it; RXDATA SHALL remain 8'h00 and no partial byte SHALL be published.

Verification
REQ-032 Reset, config ctrl GA=16'h0204 (BANK_BITS=2,NSS=2) -> BANK=2'b10, nSS=2'b00, nZPBANK=0, CPOL=0.
REQ-033 DIV=1, transfer GA=16'hA506, MISO loopback to MOSI -> BUSY high 16 cycles, MOSI sequence 1,0,1,0,0,1,0,1, RXDATA=8'hA5.
REQ-034 DIV=3, CPOL=1, transfer 8'h3C with MISO tied 1 -> SCK idles 1, 8 low pulses of 3 cycles, BUSY 48 cycles, RXDATA=8'hFF.
REQ-035 Transfer ctrl during BUSY -> second byte ignored, OVR=1; config ctrl with GA[0]=1 -> OVR=0.
REQ-036 Ctrl held asserted 5 cycles -> exactly one transfer; nRST pulsed at cycle 7 of transfer -> all outputs at reset values, RXDATA=8'h00.

Source files
------------

// File: rtl/ctrl_spi_bank_if.sv
// Gigatron-side bus and SPI pins of the bank/SPI controller.
// master: drives GA, nGOE, nGWE and MISO; observes SCK, MOSI, nSS, BANK,
//         nZPBANK, RXDATA, BUSY and OVR.
// slave : the controller; the mirror image of master.
interface ctrl_spi_bank_if #(
  parameter int unsigned BANK_BITS = 2,
  parameter int unsigned NSS       = 2
);
  logic [15:0]          GA;
  logic                 nGOE;
  logic                 nGWE;
  logic                 MISO;
  logic                 SCK;
  logic                 MOSI;
  logic [NSS-1:0]       nSS;
  logic [BANK_BITS-1:0] BANK;
  logic                 nZPBANK;
  logic [7:0]           RXDATA;
  logic                 BUSY;
  logic                 OVR;

  modport master (
    output GA, nGOE, nGWE, MISO,
    input  SCK, MOSI, nSS, BANK, nZPBANK, RXDATA, BUSY, OVR
  );

  modport slave (
    input  GA, nGOE, nGWE, MISO,
    output SCK, MOSI, nSS, BANK, nZPBANK, RXDATA, BUSY, OVR
  );
endinterface

// File: rtl/ctrl_spi_bank.sv
// Gigatron RAM bank register plus byte-wide SPI master, controlled by
// write cycles on the address bus (the address itself carries the command).
// Ports: CLK (sole clock), nRST (async active-low reset),
//        bus (slave modport): GA/nGOE/nGWE control cycle, MISO in,
//        SCK/MOSI/nSS SPI out, BANK/nZPBANK bank control, RXDATA last byte,
//        BUSY transfer active, OVR sticky rejected-while-busy flag.
// The interface must be instantiated with the same BANK_BITS/NSS.
module ctrl_spi_bank #(
  parameter int unsigned BANK_BITS = 2,
  parameter int unsigned NSS       = 2,
  parameter int unsigned DIV       = 1
) (
  input  logic            CLK,
  input  logic            nRST,
  ctrl_spi_bank_if.slave  bus
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);

  // Parameter range checks at elaboration
  if (BANK_BITS < 1 || BANK_BITS > 6) begin : g_bad_bank_bits
    $error("ctrl_spi_bank: BANK_BITS out of range 1..6");
  end
  if (NSS < 1 || NSS > 6) begin : g_bad_nss
    $error("ctrl_spi_bank: NSS out of range 1..6");
  end
  if (BANK_BITS + NSS > 8) begin : g_bad_sum
    $error("ctrl_spi_bank: BANK_BITS+NSS exceeds 8");
  end
  if (DIV < 1 || DIV > 255) begin : g_bad_div
    $error("ctrl_spi_bank: DIV out of range 1..255");
  end

  typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;

  state_t               state_q, state_d;
  logic                 ctrl_q, ctrl_prev_q;
  logic [15:0]          ga_q;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 nzp_q, nzp_d;
  logic [NSS-1:0]       nss_q, nss_d;
  logic                 cpol_q, cpol_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 sck_q, sck_d;
  logic                 mosi_q, mosi_d;
  logic [BYTE_W-1:0]    rx_q, rx_d;
  logic [BYTE_W-1:0]    tx_q, tx_d;
  logic [BYTE_W-1:0]    rxsh_q, rxsh_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DIV_W-1:0]     div_q, div_d;

  logic act_c, cfg_c, xfer_c, in_xfer_c;
  logic unused_ga;

  // Address bits 7:6 carry no meaning for this block
  assign unused_ga = ^ga_q[7:6];

  // Only the first registered cycle of a control assertion acts
  assign act_c     = ctrl_q & ~ctrl_prev_q;
  assign cfg_c     = act_c & ~ga_q[1];
  assign xfer_c    = act_c &  ga_q[1];
  assign in_xfer_c = (state_q != IDLE);

  // Control-cycle sampling
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctrl_q      <= 1'b0;
      ctrl_prev_q <= 1'b0;
      ga_q        <= 16'h0000;
    end else begin
      ctrl_q      <= ~bus.nGOE & ~bus.nGWE & (bus.GA[3:2] != 2'b00);
      ctrl_prev_q <= ctrl_q;
      ga_q        <= bus.GA;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      bank_q  <= '0;
      nzp_q   <= 1'b1;
      nss_q   <= '1;
      cpol_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      rx_q    <= '0;
      tx_q    <= '0;
      rxsh_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      nzp_q   <= nzp_d;
      nss_q   <= nss_d;
      cpol_q  <= cpol_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rxsh_q  <= rxsh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  // Command decode, SPI phase sequencing and next output values
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    nzp_d   = nzp_q;
    nss_d   = nss_q;
    cpol_d  = cpol_q;
    ovr_d   = ovr_q;
    busy_d  = busy_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rxsh_d  = rxsh_q;
    bit_d   = bit_q;
    div_d   = div_q;

    // Bank bits always follow config; SPI settings freeze during a transfer
    if (cfg_c) begin
      bank_d = ga_q[8 +: BANK_BITS];
      nzp_d  = ga_q[5];
      if (in_xfer_c) begin
        ovr_d = 1'b1;
      end else begin
        nss_d  = ga_q[8+BANK_BITS +: NSS];
        cpol_d = ga_q[4];
      end
      if (ga_q[0]) begin
        ovr_d = 1'b0;
      end
    end
    if (xfer_c && in_xfer_c) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        sck_d = cpol_d;
        if (xfer_c) begin
          state_d = LEAD;
          busy_d  = 1'b1;
          tx_d    = ga_q[15:8];
          mosi_d  = ga_q[15];
          rxsh_d  = '0;
          bit_d   = '0;
          div_d   = DIV_RELOAD;
        end
      end
      LEAD: begin
        if (div_q == '0) begin
          state_d = TRAIL;
          div_d   = DIV_RELOAD;
          sck_d   = ~cpol_q;
          rxsh_d  = {rxsh_q[BYTE_W-2:0], bus.MISO};
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      TRAIL: begin
        if (div_q == '0) begin
          div_d = DIV_RELOAD;
          sck_d = cpol_q;
          bit_d = bit_q + BIT_W'(1);
          // Bit counter wrapping 7->0 ends the byte
          if (bit_q == BIT_W'(7)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            rx_d    = rxsh_q;
          end else begin
            state_d = LEAD;
            tx_d    = {tx_q[BYTE_W-2:0], 1'b0};
            mosi_d  = tx_q[BYTE_W-2];
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.BANK    = bank_q;
  assign bus.nZPBANK = nzp_q;
  assign bus.nSS     = nss_q;
  assign bus.SCK     = sck_q;
  assign bus.MOSI    = mosi_q;
  assign bus.RXDATA  = rx_q;
  assign bus.BUSY    = busy_q;
  assign bus.OVR     = ovr_q;

endmodule
